// File: rtl/pipe_hazard_sequencer_if.sv
// Handshake bundle between the CPU pipeline control and pipe_hazard_sequencer.
// The master modport is the pipeline side; the slave modport is the sequencer.
interface pipe_hazard_sequencer_if #(
    parameter int ADDR_W = 7,
    parameter int STAT_W = 16
);
    logic              ext_stall;
    logic              ex_use_mul;
    logic              ex_branch_taken;
    logic              ex_dmem_read;
    logic [ADDR_W-1:0] ex_waddr;
    logic [ADDR_W-1:0] id_rs;
    logic [ADDR_W-1:0] id_rt;
    logic              id_rs_used;
    logic              id_rt_used;
    logic [1:0]        cond_pc;
    logic [1:0]        cond_if;
    logic [1:0]        cond_id;
    logic [1:0]        cond_ex;
    logic [1:0]        cond_me;
    logic              mul_start;
    logic              mul_busy;
    logic [STAT_W-1:0] stat_mul;
    logic [STAT_W-1:0] stat_load;
    logic [STAT_W-1:0] stat_flush;

    modport master (
        output ext_stall, ex_use_mul, ex_branch_taken, ex_dmem_read,
               ex_waddr, id_rs, id_rt, id_rs_used, id_rt_used,
        input  cond_pc, cond_if, cond_id, cond_ex, cond_me,
               mul_start, mul_busy, stat_mul, stat_load, stat_flush
    );

    modport slave (
        input  ext_stall, ex_use_mul, ex_branch_taken, ex_dmem_read,
               ex_waddr, id_rs, id_rt, id_rs_used, id_rt_used,
        output cond_pc, cond_if, cond_id, cond_ex, cond_me,
               mul_start, mul_busy, stat_mul, stat_load, stat_flush
    );
endinterface

// File: rtl/pipe_hazard_sequencer.sv
// Pipeline sequencer: per-stage FLOW/STALL/ZERO conds from ext stall, MUL occupancy, branch, load-use.
// Optional event counters are built when HAZARD_STATS_EN is defined.
`ifndef COND_FLOW
`define COND_FLOW  2'b00
`endif
`ifndef COND_STALL
`define COND_STALL 2'b01
`endif
`ifndef COND_ZERO
`define COND_ZERO  2'b10
`endif

module pipe_hazard_sequencer #(
    parameter int MUL_CYCLES = 4,
    parameter int ADDR_W     = 7,
    parameter int STAT_W     = 16
) (
    input logic                   clk,
    input logic                   rst,
    pipe_hazard_sequencer_if.slave hz
);
    typedef enum logic {IDLE, MUL_WAIT} state_e;

    localparam bit       MUL_STALLS = (MUL_CYCLES > 1);
    localparam int       CNT_LOAD_I = (MUL_CYCLES > 1) ? MUL_CYCLES - 2 : 0;
    localparam logic [3:0] CNT_LOAD = 4'(CNT_LOAD_I);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       mul_busy_q, mul_busy_d;
    logic       mul_hold;
    logic       load_use;
    logic [9:0] conds;

    always_comb begin
        mul_hold = (state_q == IDLE && hz.ex_use_mul && MUL_STALLS) ||
                   (state_q == MUL_WAIT && cnt_q != 4'd0);
        load_use = hz.ex_dmem_read && (hz.ex_waddr != {ADDR_W{1'b0}}) &&
                   ((hz.id_rs_used && hz.id_rs == hz.ex_waddr) ||
                    (hz.id_rt_used && hz.id_rt == hz.ex_waddr));
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (hz.ex_use_mul && !hz.ext_stall && MUL_STALLS) begin
                    state_d = MUL_WAIT;
                    cnt_d   = CNT_LOAD;
                end
            end
            MUL_WAIT: begin
                if (!hz.ext_stall) begin
                    if (cnt_q == 4'd0) state_d = IDLE;
                    else               cnt_d   = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Busy covers MUL_WAIT cycles still holding the pipe, not the release cycle.
        mul_busy_d = (state_d == MUL_WAIT) && (cnt_d != 4'd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            mul_busy_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mul_busy_q <= mul_busy_d;
        end
    end

    // Order of the packed conds: pc, if, id, ex, me.
    always_comb begin
        if (rst)
            conds = {5{`COND_ZERO}};
        else if (hz.ext_stall)
            conds = {5{`COND_STALL}};
        else if (mul_hold)
            conds = {`COND_STALL, `COND_STALL, `COND_STALL, `COND_ZERO, `COND_FLOW};
        else if (hz.ex_branch_taken)
            conds = {`COND_FLOW, `COND_ZERO, `COND_ZERO, `COND_FLOW, `COND_FLOW};
        else if (load_use)
            conds = {`COND_STALL, `COND_STALL, `COND_ZERO, `COND_FLOW, `COND_FLOW};
        else
            conds = {5{`COND_FLOW}};
    end

    assign hz.cond_pc   = conds[9:8];
    assign hz.cond_if   = conds[7:6];
    assign hz.cond_id   = conds[5:4];
    assign hz.cond_ex   = conds[3:2];
    assign hz.cond_me   = conds[1:0];
    assign hz.mul_start = !rst && state_q == IDLE && hz.ex_use_mul && !hz.ext_stall;
    assign hz.mul_busy  = mul_busy_q;

`ifdef HAZARD_STATS_EN
    logic [STAT_W-1:0] stat_mul_q, stat_load_q, stat_flush_q;
    logic              sel_mul, sel_flush, sel_load;

    assign sel_mul   = !hz.ext_stall && mul_hold;
    assign sel_flush = !hz.ext_stall && !mul_hold && hz.ex_branch_taken;
    assign sel_load  = !hz.ext_stall && !mul_hold && !hz.ex_branch_taken && load_use;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_mul_q   <= '0;
            stat_load_q  <= '0;
            stat_flush_q <= '0;
        end else begin
            if (sel_mul   && stat_mul_q   != '1) stat_mul_q   <= stat_mul_q   + 1'b1;
            if (sel_load  && stat_load_q  != '1) stat_load_q  <= stat_load_q  + 1'b1;
            if (sel_flush && stat_flush_q != '1) stat_flush_q <= stat_flush_q + 1'b1;
        end
    end

    assign hz.stat_mul   = stat_mul_q;
    assign hz.stat_load  = stat_load_q;
    assign hz.stat_flush = stat_flush_q;
`else
    assign hz.stat_mul   = {STAT_W{1'b0}};
    assign hz.stat_load  = {STAT_W{1'b0}};
    assign hz.stat_flush = {STAT_W{1'b0}};
`endif
endmodule
